// File: rtl/div_unit.sv
// Multi-cycle restoring divider (IDLE/ON/END) for signed and unsigned 32-bit DIV/REM.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] opdata1_i,
    input  logic [XLEN-1:0] opdata2_i,
    input  logic            annul_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    typedef enum logic [1:0] {IDLE, ON, END} state_t;

    localparam logic [5:0] LAST = 6'(XLEN - 1);

    state_t          state;
    logic [5:0]      cnt;
    logic [XLEN-1:0] dvd;      // dividend shifts out the top while quotient bits shift in
    logic [XLEN-1:0] dsr;
    logic [XLEN-1:0] rem;
    logic            n1, n2, sgn;

    logic            neg1, neg2, fit;
    logic [XLEN-1:0] abs1, abs2, rem_nxt, q_nxt, q_fix, r_fix;
    logic [XLEN:0]   diff;

    always_comb begin
        neg1    = signed_i & opdata1_i[XLEN-1];
        neg2    = signed_i & opdata2_i[XLEN-1];
        abs1    = neg1 ? -opdata1_i : opdata1_i;
        abs2    = neg2 ? -opdata2_i : opdata2_i;
        diff    = {rem, dvd[XLEN-1]} - {1'b0, dsr};
        fit     = ~diff[XLEN];
        rem_nxt = fit ? diff[XLEN-1:0] : {rem[XLEN-2:0], dvd[XLEN-1]};
        q_nxt   = {dvd[XLEN-2:0], fit};
        q_fix   = (sgn & (n1 ^ n2)) ? -q_nxt : q_nxt;
        r_fix   = (sgn & n1) ? -rem_nxt : rem_nxt;
    end

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            ready_o     <= 1'b0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            n1          <= 1'b0;
            n2          <= 1'b0;
            sgn         <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (annul_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            if (opdata2_i == '0) begin
                                quotient_o  <= '1;
                                remainder_o <= opdata1_i;
                                ready_o     <= 1'b1;
                                state       <= END;
                            end
`ifdef DIV_EARLY_OUT_EN
                            else if (abs1 < abs2) begin
                                quotient_o  <= '0;
                                remainder_o <= opdata1_i;
                                ready_o     <= 1'b1;
                                state       <= END;
                            end
`endif
                            else begin
                                dvd   <= abs1;
                                dsr   <= abs2;
                                rem   <= '0;
                                n1    <= neg1;
                                n2    <= neg2;
                                sgn   <= signed_i;
                                cnt   <= '0;
                                state <= ON;
                            end
                        end
                    end
                    ON: begin
                        dvd <= q_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 6'd1;
                        if (cnt == LAST) begin
                            quotient_o  <= q_fix;
                            remainder_o <= r_fix;
                            ready_o     <= 1'b1;
                            state       <= END;
                        end
                    end
                    END:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
